// File: rtl/pop_scheduler.sv
// Round-robin pop scheduler for the four output-stage FIFOs: grants at most one
// non-empty FIFO per cycle onto a registered shared output channel and reports IDLE.
module pop_scheduler #(
  parameter int FIFO_UNITS = 4,
  parameter int INDEX      = 2,
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_0,
  input  logic                  empty_1,
  input  logic                  empty_2,
  input  logic                  empty_3,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic                  out_ready,
  output logic                  pop_0,
  output logic                  pop_1,
  output logic                  pop_2,
  output logic                  pop_3,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [INDEX-1:0]      sel,
  output logic                  IDLE
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [INDEX-1:0]      last;
  logic [INDEX-1:0]      grant_idx;
  logic [INDEX-1:0]      cand;
  logic                  grant;
  logic                  all_empty;
  logic [FIFO_UNITS-1:0] eligible;
  logic [FIFO_UNITS-1:0] pop_vec;
  logic [DATA_WIDTH-1:0] heads [FIFO_UNITS];

  assign eligible  = ~{empty_3, empty_2, empty_1, empty_0};
  assign all_empty = ~|eligible;
  assign heads[0]  = data_in_0;
  assign heads[1]  = data_in_1;
  assign heads[2]  = data_in_2;
  assign heads[3]  = data_in_3;

  // Search last+1 .. last+4 (mod 4); the index width wraps naturally.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (reset && out_ready) begin
      for (int k = 1; k <= FIFO_UNITS; k++) begin
        cand = last + INDEX'(k);
        if (!grant && eligible[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    pop_vec = '0;
    if (grant) pop_vec[grant_idx] = 1'b1;
  end

  assign pop_0 = pop_vec[0];
  assign pop_1 = pop_vec[1];
  assign pop_2 = pop_vec[2];
  assign pop_3 = pop_vec[3];

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:   next_state = all_empty ? ST_IDLE : ST_ACTIVE;
      ST_IDLE:   next_state = all_empty ? ST_IDLE : ST_ACTIVE;
      ST_ACTIVE: next_state = (all_empty && !grant) ? ST_IDLE : ST_ACTIVE;
      default:   next_state = ST_INIT;
    endcase
  end

  // IDLE is registered alongside the state so it mirrors a decode of it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_INIT;
      last      <= INDEX'(FIFO_UNITS - 1);
      data_out  <= '0;
      sel       <= '0;
      valid_out <= 1'b0;
      IDLE      <= 1'b0;
    end else begin
      state <= next_state;
      IDLE  <= (next_state == ST_IDLE);
      if (grant) begin
        last      <= grant_idx;
        data_out  <= heads[grant_idx];
        sel       <= grant_idx;
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pop_scheduler.sv
// Self-checking bench for pop_scheduler: FIFOs are modelled as queues and the
// expected grants/outputs come from a behavioural round-robin model.
module tb_pop_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       empty_0, empty_1, empty_2, empty_3;
  logic [5:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic       out_ready;
  logic       pop_0, pop_1, pop_2, pop_3;
  logic [5:0] data_out;
  logic       valid_out;
  logic [1:0] sel;
  logic       IDLE;

  int total = 0;
  int bad   = 0;

  logic [5:0] fifo_q [4][$];

  int         m_last  = 3;
  logic [5:0] m_data  = '0;
  int         m_sel   = 0;
  bit         m_valid = 1'b0;
  int         m_mode  = 0;

  always #5 clk = ~clk;

  pop_scheduler dut (
    .clk(clk), .reset(reset),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2), .empty_3(empty_3),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .data_in_2(data_in_2), .data_in_3(data_in_3),
    .out_ready(out_ready),
    .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
    .data_out(data_out), .valid_out(valid_out), .sel(sel), .IDLE(IDLE)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic setInputs();
    empty_0   = (fifo_q[0].size() == 0);
    empty_1   = (fifo_q[1].size() == 0);
    empty_2   = (fifo_q[2].size() == 0);
    empty_3   = (fifo_q[3].size() == 0);
    data_in_0 = empty_0 ? 6'h00 : fifo_q[0][0];
    data_in_1 = empty_1 ? 6'h00 : fifo_q[1][0];
    data_in_2 = empty_2 ? 6'h00 : fifo_q[2][0];
    data_in_3 = empty_3 ? 6'h00 : fifo_q[3][0];
  endtask

  function automatic int modelGrant();
    if (!reset || !out_ready) return -1;
    for (int k = 1; k <= 4; k++) begin
      int idx = (m_last + k) % 4;
      if (fifo_q[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check away from the edge, then advance the model.
  task automatic applyStimulus(input bit rst_val, input bit rdy);
    int       g;
    bit       none_full;
    logic [3:0] exp_pop;
    reset     = rst_val;
    out_ready = rdy;
    setInputs();
    g = modelGrant();
    none_full = 1'b1;
    for (int i = 0; i < 4; i++) if (fifo_q[i].size() > 0) none_full = 1'b0;
    exp_pop = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    @(negedge clk);
    checkOutput("pop", {28'd0, pop_3, pop_2, pop_1, pop_0}, {28'd0, exp_pop});
    checkOutput("data_out", {26'd0, data_out}, {26'd0, m_data});
    checkOutput("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
    checkOutput("sel", {30'd0, sel}, m_sel);
    checkOutput("idle", {31'd0, IDLE}, {31'd0, (m_mode == 1)});
    @(posedge clk);
    if (!rst_val) begin
      m_last = 3; m_data = '0; m_sel = 0; m_valid = 1'b0; m_mode = 0;
    end else begin
      if (g >= 0) begin
        m_last  = g;
        m_data  = fifo_q[g][0];
        m_sel   = g;
        m_valid = 1'b1;
        void'(fifo_q[g].pop_front());
      end else begin
        m_valid = 1'b0;
      end
      if (m_mode == 2) m_mode = (none_full && g < 0) ? 1 : 2;
      else             m_mode = none_full ? 1 : 2;
    end
    #1;
  endtask

  task automatic clearAll();
    for (int i = 0; i < 4; i++) fifo_q[i].delete();
  endtask

  initial begin
    reset     = 1'b0;
    out_ready = 1'b0;
    setInputs();
    @(posedge clk);
    #1;

    // Reset held with all FIFOs empty, then release into IDLE.
    repeat (2) applyStimulus(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b1);

    // All four FIFOs full with constant heads.
    for (int i = 0; i < 4; i++) repeat (5) fifo_q[i].push_back(6'(i + 1));
    repeat (8) applyStimulus(1'b1, 1'b1);
    clearAll();
    repeat (2) applyStimulus(1'b1, 1'b1);

    // Only FIFOs 1 and 3; FIFO 1 runs dry first.
    repeat (2) fifo_q[1].push_back(6'h11);
    for (int i = 0; i < 6; i++) fifo_q[3].push_back(6'(6'h30 + i));
    repeat (7) applyStimulus(1'b1, 1'b1);

    // Backpressure on FIFO 2.
    clearAll();
    for (int i = 0; i < 3; i++) fifo_q[2].push_back(6'(6'h20 + i));
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    clearAll();

    // Drain FIFO 0 to IDLE, then refill FIFO 1.
    repeat (2) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) fifo_q[0].push_back(6'(6'h0a + i));
    repeat (6) applyStimulus(1'b1, 1'b1);
    fifo_q[1].push_back(6'h15);
    repeat (3) applyStimulus(1'b1, 1'b1);

    // Reset in the middle of a stream: pointer returns to FIFO 0 first.
    for (int i = 0; i < 4; i++) begin
      fifo_q[0].push_back(6'(6'h01 + i));
      fifo_q[1].push_back(6'(6'h21 + i));
    end
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b1);
    clearAll();

    // Randomised traffic, backpressure and occasional resets.
    for (int c = 0; c < 400; c++) begin
      int pushes = $urandom_range(0, 2);
      for (int p = 0; p < pushes; p++) begin
        int f = $urandom_range(0, 3);
        if (fifo_q[f].size() < 8) fifo_q[f].push_back(6'($urandom));
      end
      applyStimulus(($urandom % 40) != 0, ($urandom % 4) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
